// File: rtl/reg_load_arbiter_if.sv
// Write-request bundle between four register write sources and the arbiter.
// Requesters drive req/data_in; the arbiter returns grant/load/done/busy and the stored value.
interface reg_load_arbiter_if #(
  parameter int BUS_WIDTH = 8
);
  logic [3:0]             req;
  logic [4*BUS_WIDTH-1:0] data_in;
  logic [3:0]             grant;
  logic                   load;
  logic                   done;
  logic                   busy;
  logic [BUS_WIDTH-1:0]   out;

  modport master (
    output req,
    output data_in,
    input  grant,
    input  load,
    input  done,
    input  busy,
    input  out
  );

  modport slave (
    input  req,
    input  data_in,
    output grant,
    output load,
    output done,
    output busy,
    output out
  );
endinterface

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one load-enabled register among four writers; grant 1 cycle after req,
// out updates 1 cycle later; the owner holds the block in ACK (others stall) until it drops req.
module reg_load_arbiter #(
  parameter int BUS_WIDTH = 8
) (
  input logic              clock,
  input logic              reset_n,
  reg_load_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t               state_q, state_d;
  logic [3:0]           grant_q, grant_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           pick;
  logic                 found;
  logic [BUS_WIDTH-1:0] out_q;
  logic                 load;

  // Scan from the requester after the last winner, wrapping mod 4.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && bus.req[last_q + 2'(k)]) begin
        found = 1'b1;
        pick  = last_q + 2'(k);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // last_q doubles as the granted index while in GRANT/ACK.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = 4'b0001 << pick;
          last_d  = pick;
          state_d = GRANT;
        end
      end
      GRANT: state_d = ACK;
      ACK: begin
        if (!bus.req[last_q]) begin
          grant_d = 4'b0000;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  assign load = (state_q == GRANT);

  // Shared storage register: plain load-enabled D flip-flop behind the input mux.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
    end else if (load) begin
      out_q <= bus.data_in[last_q*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  assign bus.grant = grant_q;
  assign bus.load  = load;
  assign bus.done  = (state_q == ACK);
  assign bus.busy  = (state_q != IDLE);
  assign bus.out   = out_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter: transaction-level model checked every cycle plus literal pins.
module tb_reg_load_arbiter;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  reg_load_arbiter_if #(.BUS_WIDTH(W)) bus ();

  reg_load_arbiter #(.BUS_WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: an owner holds the register for a transaction; the first owned cycle writes,
  // later owned cycles acknowledge until the owner drops its request.
  int         owner = -1;
  int         age   = 0;
  int         last  = 3;
  logic [W-1:0] m_out = '0;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      owner = -1; age = 0; last = 3; m_out = '0;
    end else if (owner < 0) begin
      for (int k = 1; k <= 4; k++)
        if (owner < 0 && bus.req[(last + k) % 4]) owner = (last + k) % 4;
      if (owner >= 0) begin
        last = owner;
        age  = 0;
      end
    end else if (age == 0) begin
      m_out = bus.data_in[owner*W +: W];
      age   = 1;
    end else if (!bus.req[owner]) begin
      owner = -1;
    end
  end

  initial forever begin
    @(negedge clock);
    chk("cmp_grant", {28'd0, bus.grant}, (owner < 0) ? 32'd0 : (32'd1 << owner));
    chk("cmp_load",  {31'd0, bus.load},  {31'd0, (owner >= 0 && age == 0)});
    chk("cmp_done",  {31'd0, bus.done},  {31'd0, (owner >= 0 && age >= 1)});
    chk("cmp_busy",  {31'd0, bus.busy},  {31'd0, (owner >= 0)});
    chk("cmp_out",   {24'd0, bus.out},   {24'd0, m_out});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] v);
    bus.data_in[i*W +: W] = v;
  endtask

  logic [3:0] rr_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] rr_data  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

  initial begin
    reset_n     = 1'b0;
    bus.req     = 4'b1111;
    bus.data_in = '0;
    set_slice(0, 8'h11); set_slice(1, 8'h22); set_slice(2, 8'h33); set_slice(3, 8'h44);

    // Reset held with all requests high, then round-robin from requester 0.
    step(3);
    chk("rst_grant", {28'd0, bus.grant}, 32'd0);
    chk("rst_load",  {31'd0, bus.load},  32'd0);
    chk("rst_done",  {31'd0, bus.done},  32'd0);
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_out",   {24'd0, bus.out},   32'd0);
    reset_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      int g;
      for (int c = 0; c < 20 && bus.grant == 4'b0000; c++) @(negedge clock);
      chk("rr_grant", {28'd0, bus.grant}, {28'd0, rr_grant[n]});
      for (int c = 0; c < 20 && !bus.done; c++) @(negedge clock);
      chk("rr_out", {24'd0, bus.out}, {24'd0, rr_data[n]});
      g = 0;
      for (int b = 0; b < 4; b++) if (rr_grant[n][b]) g = b;
      bus.req[g] = 1'b0;
      step(1);
      if (n < 4) bus.req[g] = 1'b1;
    end
    bus.req = 4'b0000;
    step(3);

    // Withdrawal during GRANT (last winner 0, so requester 1 is granted).
    set_slice(1, 8'h09);
    bus.req = 4'b0010;
    step(1);
    chk("wd_grant", {28'd0, bus.grant}, 32'h2);
    chk("wd_load",  {31'd0, bus.load},  32'd1);
    bus.req = 4'b0000;
    step(1);
    chk("wd_done", {31'd0, bus.done}, 32'd1);
    chk("wd_out",  {24'd0, bus.out},  32'h09);
    step(1);
    chk("wd_idle_done", {31'd0, bus.done}, 32'd0);
    chk("wd_idle_busy", {31'd0, bus.busy}, 32'd0);
    step(1);

    // Hold in ACK: requester 3 keeps ownership while requester 0 waits.
    set_slice(3, 8'hAA);
    set_slice(0, 8'h0F);
    bus.req = 4'b1001;
    step(2);
    chk("hold_done", {31'd0, bus.done}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("hold_grant", {28'd0, bus.grant}, 32'h8);
      chk("hold_out",   {24'd0, bus.out},   32'hAA);
    end
    bus.req[3] = 1'b0;
    step(1);
    chk("hold_release", {28'd0, bus.grant}, 32'h0);
    step(1);
    chk("hold_next", {28'd0, bus.grant}, 32'h1);
    step(1);
    chk("hold_next_out", {24'd0, bus.out}, 32'h0F);
    bus.req = 4'b0000;
    step(2);

    // Single write from requester 2.
    set_slice(2, 8'h5A);
    bus.req = 4'b0100;
    step(1);
    chk("sw_grant", {28'd0, bus.grant}, 32'h4);
    chk("sw_load",  {31'd0, bus.load},  32'd1);
    step(1);
    chk("sw_load_off", {31'd0, bus.load}, 32'd0);
    chk("sw_out",      {24'd0, bus.out},  32'h5A);
    chk("sw_done",     {31'd0, bus.done}, 32'd1);
    bus.req = 4'b0000;
    step(1);
    chk("sw_grant_clr", {28'd0, bus.grant}, 32'h0);
    chk("sw_busy",      {31'd0, bus.busy},  32'd0);
    step(1);

    // Asynchronous reset mid-GRANT aborts the write of slice 0 (last winner 2 -> scan finds 0).
    bus.req = 4'b0001;
    step(1);
    chk("ar_load", {31'd0, bus.load}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out",   {24'd0, bus.out},   32'd0);
    chk("ar_grant", {28'd0, bus.grant}, 32'd0);
    chk("ar_busy",  {31'd0, bus.busy},  32'd0);
    bus.req = 4'b1001;
    #1 reset_n = 1'b1;
    step(1);
    chk("ar_no_done",  {31'd0, bus.done}, 32'd0);
    chk("ar_restart",  {28'd0, bus.grant}, 32'h1);
    step(1);
    chk("ar_commit", {24'd0, bus.out}, 32'h0F);
    bus.req = 4'b0000;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
